// File: rtl/reg_file_sb.sv
// Datapath register file: two combinational read ports, one synchronous write port,
// and a per-register busy scoreboard with optional write->read bypass and zero R0.
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ok,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  wr_fire;
  logic                  rsv_set;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  // Addresses that hold real, writable state (excludes hardwired R0 and out-of-range).
  function automatic logic storable(input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_fire  = wr_en && !rst && storable(wr_addr);
  assign rsv_ok   = rsv_en && !rst && in_range(rsv_addr) &&
                    (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
  assign rsv_set  = rsv_ok && storable(rsv_addr);
  assign busy_vec = busy;

  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    if (storable(rd_addr_a)) begin
      if (BYPASS && wr_fire && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = regs[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    if (storable(rd_addr_b)) begin
      if (BYPASS && wr_fire && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = regs[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
      end
    end
  end

  // Release happens before reserve so a same-register write+reserve ends busy.
  always_comb begin
    busy_next = busy;
    if (wr_fire) busy_next[wr_addr] = 1'b0;
    if (rsv_set) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_next;
      if (wr_fire) regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: table of per-cycle vectors plus reset sequences,
// with a second BYPASS=0 instance sharing the same stimulus.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [7:0] wr_data;
  logic       wr_en, rsv_en;
  logic [7:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;
  logic       rd_busy_a, rd_busy_b, nb_busy_a, nb_busy_b;
  logic       rsv_ok, nb_rsv_ok;
  logic [7:0] busy_vec, nb_busy_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_vec(busy_vec)
  );

  reg_file_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(nb_data_a), .rd_busy_a(nb_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(nb_data_b), .rd_busy_b(nb_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok), .busy_vec(nb_busy_vec)
  );

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic [7:0] e_a;
    logic       e_busy_a;
    logic [7:0] e_b;
    logic       e_busy_b;
    logic       e_ok;
    logic [7:0] e_vec;
    logic [7:0] e_nb_a;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic re, input logic [2:0] ra,
                       input logic [2:0] a, input logic [2:0] b);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_addr_a = a; rd_addr_b = b;
  endtask

  initial begin
    //          we wa  wd     re ra  a  b   e_a    ba e_b   bb ok e_vec  nb_a
    vecs[0]  = '{1, 3, 8'hA5, 0, 0, 3, 3, 8'hA5, 0, 8'hA5, 0, 0, 8'h00, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 3, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 8'hA5};
    vecs[2]  = '{0, 0, 8'h00, 1, 5, 5, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00};
    vecs[3]  = '{0, 0, 8'h00, 1, 5, 5, 3, 8'h00, 1, 8'hA5, 0, 0, 8'h20, 8'h00};
    vecs[4]  = '{1, 5, 8'h3C, 0, 0, 5, 5, 8'h3C, 0, 8'h3C, 0, 0, 8'h20, 8'h00};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 5, 3, 8'h3C, 0, 8'hA5, 0, 0, 8'h00, 8'h3C};
    vecs[6]  = '{0, 0, 8'h00, 1, 2, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00};
    vecs[7]  = '{1, 2, 8'h11, 1, 2, 2, 0, 8'h11, 0, 8'h00, 0, 1, 8'h04, 8'h00};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 2, 0, 8'h11, 1, 8'h00, 0, 0, 8'h04, 8'h11};
    vecs[9]  = '{1, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h04, 8'h00};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 0, 2, 8'h00, 0, 8'h11, 1, 0, 8'h04, 8'h00};
    vecs[11] = '{1, 2, 8'h22, 1, 6, 2, 6, 8'h22, 0, 8'h00, 0, 1, 8'h04, 8'h11};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 2, 6, 8'h22, 0, 8'h00, 1, 0, 8'h40, 8'h22};
    vecs[13] = '{1, 1, 8'h77, 0, 0, 1, 1, 8'h77, 0, 8'h77, 0, 0, 8'h40, 8'h00};
    vecs[14] = '{1, 6, 8'h5A, 1, 2, 6, 1, 8'h5A, 0, 8'h77, 0, 1, 8'h40, 8'h00};
    vecs[15] = '{0, 0, 8'h00, 1, 3, 3, 2, 8'hA5, 0, 8'h22, 1, 1, 8'h04, 8'hA5};
    vecs[16] = '{0, 0, 8'h00, 1, 5, 5, 1, 8'h3C, 0, 8'h77, 0, 1, 8'h0C, 8'h3C};
    vecs[17] = '{0, 0, 8'h00, 0, 0, 1, 5, 8'h77, 0, 8'h3C, 1, 0, 8'h2C, 8'h77};

    // Reset with a reserve request pending; check every address while rst is still high.
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd0, 3'd0);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      rsv_addr  = 3'(i);
      #2;
      check("rst_rd_a", i, rd_data_a, 8'h00);
      check("rst_rd_b", i, rd_data_b, 8'h00);
      check("rst_busy_a", i, rd_busy_a, 1'b0);
      check("rst_rsv_ok", i, rsv_ok, 1'b0);
      check("rst_busy_vec", i, busy_vec, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
            vecs[i].rsv_en, vecs[i].rsv_addr, vecs[i].rd_a, vecs[i].rd_b);
      #2;
      check("rd_data_a", i, rd_data_a, vecs[i].e_a);
      check("rd_busy_a", i, rd_busy_a, vecs[i].e_busy_a);
      check("rd_data_b", i, rd_data_b, vecs[i].e_b);
      check("rd_busy_b", i, rd_busy_b, vecs[i].e_busy_b);
      check("rsv_ok", i, rsv_ok, vecs[i].e_ok);
      check("busy_vec", i, busy_vec, vecs[i].e_vec);
      check("nb_rd_data_a", i, nb_data_a, vecs[i].e_nb_a);
      check("nb_busy_vec", i, nb_busy_vec, vecs[i].e_vec);
    end

    // Mid-operation reset with busy_vec=2C, R1=77; write/reserve in the same cycle are overridden.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3'd1, 8'hFF, 1'b1, 3'd4, 3'd1, 3'd4);
    #2;
    check("midrst_rsv_ok", 0, rsv_ok, 1'b0);
    check("midrst_rd_a", 0, rd_data_a, 8'h77);
    check("midrst_busy_vec", 0, busy_vec, 8'h2C);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd5);
    #2;
    check("postrst_busy_vec", 0, busy_vec, 8'h00);
    check("postrst_rd_a", 0, rd_data_a, 8'h00);
    check("postrst_rd_b", 0, rd_data_b, 8'h00);
    check("postrst_busy_b", 0, rd_busy_b, 1'b0);
    check("postrst_nb_rd_a", 0, nb_data_a, 8'h00);

    // Requester holds rsv_en on a busy register and succeeds once it is released.
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd7, 3'd7);
    #2;
    check("hold_first_ok", 0, rsv_ok, 1'b1);
    @(negedge clk);
    #2;
    check("hold_retry_ok", 0, rsv_ok, 1'b0);
    check("hold_busy_vec", 0, busy_vec, 8'h80);
    @(negedge clk);
    #2;
    check("hold_still_rej", 0, rsv_ok, 1'b0);
    check("hold_busy_a", 0, rd_busy_a, 1'b1);
    @(negedge clk);
    rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h9E;
    #2;
    check("hold_nb_busy_a", 0, nb_busy_a, 1'b1);
    check("hold_nb_data_a", 0, nb_data_a, 8'h00);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd7, 3'd7);
    #2;
    check("hold_after_wr_ok", 0, rsv_ok, 1'b1);
    check("hold_after_wr_data", 0, rd_data_a, 8'h9E);
    check("hold_after_wr_vec", 0, busy_vec, 8'h00);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd7, 3'd0);
    #2;
    check("hold_final_vec", 0, busy_vec, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
